// File: rtl/aes_pkg.sv
// Shared AES-128 types, round-constant table and the linear round helpers.
package aes_pkg;

   localparam int unsigned AES_NR = 10;

   typedef logic [7:0]        byte_t;
   // Byte 0 is the most significant byte; byte k sits at column k/4, row k%4.
   typedef logic [0:15][7:0]  state_t;
   typedef logic [0:3][7:0]   word_t;
   typedef logic [127:0]      rk_array_t [0:AES_NR];

   typedef enum logic [1:0] {
      S_IDLE,
      S_KEXP,
      S_ENC
   } fsm_t;

   localparam logic [1:10][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r of the state rotates left by r columns.
   function automatic state_t shift_rows(input state_t s);
      state_t o;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            o[4*c + r] = s[4*((c + r) % 4) + r];
         end
      end
      return o;
   endfunction

   function automatic state_t mix_columns(input state_t s);
      state_t o;
      byte_t  a0, a1, a2, a3;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[4*c];
         a1 = s[4*c + 1];
         a2 = s[4*c + 2];
         a3 = s[4*c + 3];
         o[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Full 256-entry substitution table.
   always_comb begin
      y = 8'h00;
      case (a)
         8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
         8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
         8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
         8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
         8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
         8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
         8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
         8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
         8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
         8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
         8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
         8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
         8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
         8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
         8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
         8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
         8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
         8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
         8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
         8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
         8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
         8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
         8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
         8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
         8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
         8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
         8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
         8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
         8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
         8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
         8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
         8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
      endcase
   end

endmodule

// File: rtl/aes_128_top.sv
// Iterative AES-128 encryptor: key expanded once into 11 round keys, one round per clock.
module aes_128_top
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR  // must stay 10 for AES-128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key_i,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic [127:0] data_i,
   input  logic         data_valid_i,
   output logic         data_ready_o,
   output logic [127:0] data_o,
   output logic         data_valid_o
);

   localparam logic [3:0] LAST = 4'(NR);

   fsm_t         state, state_next;
   logic         key_loaded;
   rk_array_t    round_keys;
   state_t       st;
   logic [3:0]   round;   // shared by KEXP (key index) and ENC (round index)

   logic [7:0]   sb [16];
   state_t       sb_state, sr, mc, enc_next;
   logic [127:0] rk_cur;

   logic [127:0] key_prev, kexp_next;
   word_t        rot, temp;
   logic [7:0]   ksb [4];
   logic [31:0]  w0, w1, w2, w3;

   for (genvar i = 0; i < 16; i++) begin : g_data_sbox
      aes_sbox u_sbox (.a(st[i]), .y(sb[i]));
   end

   for (genvar i = 0; i < 4; i++) begin : g_key_sbox
      aes_sbox u_sbox (.a(rot[i]), .y(ksb[i]));
   end

   // RotWord of the last word of the previous round key feeds the SubWord S-boxes.
   assign key_prev = round_keys[round - 4'd1];
   assign rot      = {key_prev[23:16], key_prev[15:8], key_prev[7:0], key_prev[31:24]};

   // Next round key from the previous one.
   always_comb begin
      temp      = {ksb[0] ^ RCON[round], ksb[1], ksb[2], ksb[3]};
      w0        = key_prev[127:96] ^ temp;
      w1        = key_prev[95:64]  ^ w0;
      w2        = key_prev[63:32]  ^ w1;
      w3        = key_prev[31:0]   ^ w2;
      kexp_next = {w0, w1, w2, w3};
   end

   // One encryption round; the last round skips MixColumns.
   always_comb begin
      for (int unsigned i = 0; i < 16; i++) begin
         sb_state[i] = sb[i];
      end
      sr       = shift_rows(sb_state);
      mc       = mix_columns(sr);
      rk_cur   = round_keys[round];
      enc_next = (round == LAST) ? (sr ^ rk_cur) : (mc ^ rk_cur);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // FSM next state and handshake outputs; a key write takes priority over data.
   always_comb begin
      state_next   = state;
      key_ready_o  = 1'b0;
      data_ready_o = 1'b0;
      case (state)
         S_IDLE: begin
            key_ready_o  = 1'b1;
            data_ready_o = key_loaded & ~key_valid_i;
            if (key_valid_i)                     state_next = S_KEXP;
            else if (data_valid_i && key_loaded) state_next = S_ENC;
         end
         S_KEXP:  if (round == LAST) state_next = S_IDLE;
         S_ENC:   if (round == LAST) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Round-key file, cipher state, round counter and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_loaded   <= 1'b0;
         round_keys   <= '{default: '0};
         st           <= '0;
         round        <= '0;
         data_o       <= '0;
         data_valid_o <= 1'b0;
      end else begin
         data_valid_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (key_valid_i) begin
                  round_keys[0] <= key_i;
                  key_loaded    <= 1'b0;
                  round         <= 4'd1;
               end else if (data_valid_i && key_loaded) begin
                  st    <= data_i ^ round_keys[0];
                  round <= 4'd1;
               end
            end
            S_KEXP: begin
               round_keys[round] <= kexp_next;
               if (round == LAST) begin
                  key_loaded <= 1'b1;
                  round      <= '0;
               end else begin
                  round <= round + 4'd1;
               end
            end
            S_ENC: begin
               if (round == LAST) begin
                  data_o       <= enc_next;
                  data_valid_o <= 1'b1;
                  round        <= '0;
               end else begin
                  st    <= enc_next;
                  round <= round + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_128_top.sv
// Self-checking bench for aes_128_top against a byte-level AES-128 reference model.
module tb_aes_128_top;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] key;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] data;
   logic         data_valid;
   logic         data_ready;
   logic [127:0] dout;
   logic         dout_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] sbox_tab [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_128_top #(.NR(10)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_i        (key),
      .key_valid_i  (key_valid),
      .key_ready_o  (key_ready),
      .data_i       (data),
      .data_valid_i (data_valid),
      .data_ready_o (data_ready),
      .data_o       (dout),
      .data_valid_o (dout_valid)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b};
      return d[15-n -: 8];
   endfunction

   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [7:0]   s [16];
      logic [7:0]   u [16];
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int b = 0; b < 16; b++) u[b] = sbox_tab[s[b]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r + 4*c] = u[r + 4*((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int b = 0; b < 16; b++) s[b] ^= w[4*rnd + b/4][31-8*(b%4) -: 8];
      end
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
      return res;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic watch(input int n, output int strobes);
      strobes = 0;
      repeat (n) begin
         @(negedge clk);
         if (dout_valid) strobes++;
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      int n;
      @(negedge clk);
      key       = k;
      key_valid = 1'b1;
      #1;
      check("key_ready_idle", key_ready, 1);
      if (data_valid) check("data_ready_vs_key", data_ready, 0);
      @(posedge clk);
      #1;
      key_valid  = 1'b0;
      data_valid = 1'b0;
      check("kexp_key_ready", key_ready, 0);
      check("kexp_data_ready", data_ready, 0);
      n = 0;
      while (!key_ready && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("kexp_cycles", n, 10);
   endtask

   task automatic encrypt(input string tag, input logic [127:0] pt, input logic [127:0] exp);
      int n, acc;
      @(negedge clk);
      data       = pt;
      data_valid = 1'b1;
      #1;
      check({tag, "_ready"}, data_ready, 1);
      acc = cyc;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dout_valid && n < 30);
      check({tag, "_strobe"}, dout_valid, 1);
      check({tag, "_data"}, dout, exp);
      check({tag, "_latency"}, cyc - acc, 11);
      @(negedge clk);
      check({tag, "_one_shot"}, dout_valid, 0);
      check({tag, "_hold"}, dout, exp);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int           strobes, got, acc;
      int           scyc [4];
      int           acyc [4];
      logic [127:0] sdat [4];
      logic [127:0] k, p1, p2;

      rst_n      = 1'b0;
      key        = '0;
      key_valid  = 1'b0;
      data       = '0;
      data_valid = 1'b0;
      build_sbox();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", dout_valid, 0);
      check("rst_data", dout, 0);
      check("rst_key_ready", key_ready, 1);
      check("rst_data_ready", data_ready, 0);
      check("rst_key_loaded", dut.key_loaded, 0);
      rst_n = 1'b1;

      // Data before any key: never accepted.
      data       = 128'h0123456789abcdef0123456789abcdef;
      data_valid = 1'b1;
      #1;
      check("nokey_data_ready", data_ready, 0);
      watch(15, strobes);
      check("nokey_strobes", strobes, 0);

      // Key and data together: key wins, the data word is dropped.
      load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      watch(15, strobes);
      check("key_wins_strobes", strobes, 0);
      check("rk10", dut.round_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      encrypt("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);

      load_key(128'h000102030405060708090a0b0c0d0e0f);
      encrypt("fips_c1", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      load_key('0);
      encrypt("zero_1", '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      encrypt("zero_2", '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

      // Back-to-back blocks with data_valid held high.
      p1  = {$urandom, $urandom, $urandom, $urandom};
      p2  = {$urandom, $urandom, $urandom, $urandom};
      got = 0;
      acc = 0;
      @(negedge clk);
      data       = p1;
      data_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (dout_valid && got < 4) begin
            scyc[got] = cyc;
            sdat[got] = dout;
            got++;
         end
         if (data_valid && data_ready && acc < 4) begin
            acyc[acc] = cyc;
            acc++;
         end
         @(posedge clk);
         #1;
         if (acc == 1) data = p2;
         if (acc >= 2) data_valid = 1'b0;
         @(negedge clk);
      end
      data_valid = 1'b0;
      check("b2b_accepts", acc, 2);
      check("b2b_strobes", got, 2);
      if (got == 2 && acc == 2) begin
         check("b2b_data1", sdat[0], ref_encrypt('0, p1));
         check("b2b_data2", sdat[1], ref_encrypt('0, p2));
         check("b2b_gap", scyc[1] - scyc[0], 11);
         check("b2b_accept_in_strobe", acyc[1], scyc[0]);
      end

      // Random keys and blocks against the reference model.
      for (int i = 0; i < 5; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         load_key(k);
         for (int j = 0; j < 2; j++) begin
            p1 = {$urandom, $urandom, $urandom, $urandom};
            encrypt("rand", p1, ref_encrypt(k, p1));
         end
      end

      // Reset in the middle of an encryption.
      @(negedge clk);
      data       = {$urandom, $urandom, $urandom, $urandom};
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_valid", dout_valid, 0);
      check("midrst_data", dout, 0);
      check("midrst_key_loaded", dut.key_loaded, 0);
      @(negedge clk);
      rst_n = 1'b1;
      watch(25, strobes);
      check("midrst_no_strobe", strobes, 0);
      check("midrst_data_ready", data_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
